// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer slice.
package conv_pkg;

  localparam int unsigned BANK_IDX_W = 3;

  localparam logic KMODE_3X3 = 1'b0;
  localparam logic KMODE_5X5 = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    IFMD_WAIT,
    IFMD_WR,
    KW_WAIT,
    KW_WR,
    CALC,
    DRAIN,
    READ,
    DONE
  } conv_state_t;

endpackage

// File: rtl/conv_drain_pipe.sv
// CALC-delay pipe driving the ofmd write-address advance, plus the DRAIN cycle counter.
module conv_drain_pipe #(
  parameter int unsigned POST_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic calc_active,
  input  logic drain_active,
  output logic ofmd_wr_addr_en,
  output logic drain_last
);

  // The address advance taps CALC delayed max(POST_LAT-1,1) cycles; deeper taps are never observed.
  localparam int unsigned PIPE_W = (POST_LAT > 1) ? POST_LAT - 1 : 1;
  localparam logic [3:0] DRAIN_END = 4'(POST_LAT - 1);

  logic [PIPE_W-1:0] calc_pipe;
  logic [3:0]        drain_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      calc_pipe <= '0;
    end else begin
      calc_pipe[0] <= calc_active;
      for (int unsigned i = 1; i < PIPE_W; i++) begin
        calc_pipe[i] <= calc_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt <= '0;
    end else if (drain_active && !drain_last) begin
      drain_cnt <= drain_cnt + 4'd1;
    end else begin
      drain_cnt <= '0;
    end
  end

  assign drain_last      = drain_active && (drain_cnt == DRAIN_END);
  assign ofmd_wr_addr_en = calc_pipe[PIPE_W-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Top-level sequencer: ifmd/kernel bank loads, calc, drain and ofmd readout.
// Optional CONV_FRAME_LOOP_EN: DONE returns to IDLE after one cycle for back-to-back frames.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned IFMD_BANKS = 2,
  parameter int unsigned KW_BANKS   = 4,
  parameter int unsigned POST_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_st_ifmd,
  input  logic                  ifmd_wr_done,
  input  logic                  in_st_kw,
  input  logic                  kw_is_5_5,
  input  logic                  kw_wr_done,
  input  logic                  calc_done,
  input  logic                  ofmd_rd_done,
  output logic [IFMD_BANKS-1:0] ifmd_ram_en,
  output logic [IFMD_BANKS-1:0] ifmd_wr,
  output logic [KW_BANKS-1:0]   kw_ram_en,
  output logic [KW_BANKS-1:0]   kw_wr,
  output logic [BANK_IDX_W-1:0] bank_idx,
  output logic                  is_5x5,
  output logic                  rd_enable,
  output logic                  ofmd_wr_addr_en,
  output logic                  ofmd_ram_en,
  output logic                  ofmd_rd_en,
  output logic                  out_st,
  output logic                  ifmd_wr_state,
  output logic                  kw_wr_state,
  output logic                  done
);

  localparam logic [BANK_IDX_W-1:0] IFMD_LAST = BANK_IDX_W'(IFMD_BANKS - 1);
  localparam logic [BANK_IDX_W-1:0] KW_LAST   = BANK_IDX_W'(KW_BANKS - 1);

  conv_state_t           state, next_state;
  logic [BANK_IDX_W-1:0] next_idx;
  logic                  next_5x5;
  logic                  drain_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bank_idx <= '0;
      is_5x5   <= KMODE_3X3;
      out_st   <= 1'b0;
    end else begin
      state    <= next_state;
      bank_idx <= next_idx;
      is_5x5   <= next_5x5;
      out_st   <= (next_state == READ) && (state != READ);
    end
  end

  // In WR states only the done input is examined, so a coincident start is dropped.
  always_comb begin
    next_state = state;
    next_idx   = bank_idx;
    next_5x5   = is_5x5;
    unique case (state)
      IDLE: begin
        if (in_st_ifmd) begin
          next_state = IFMD_WR;
          next_idx   = '0;
        end
      end
      IFMD_WAIT: begin
        if (in_st_ifmd) next_state = IFMD_WR;
      end
      IFMD_WR: begin
        if (ifmd_wr_done) begin
          if (bank_idx == IFMD_LAST) begin
            next_state = KW_WAIT;
            next_idx   = '0;
          end else begin
            next_state = IFMD_WAIT;
            next_idx   = bank_idx + 1'b1;
          end
        end
      end
      KW_WAIT: begin
        if (in_st_kw) begin
          next_state = KW_WR;
          if (bank_idx == '0) next_5x5 = kw_is_5_5 ? KMODE_5X5 : KMODE_3X3;
        end
      end
      KW_WR: begin
        if (kw_wr_done) begin
          if (bank_idx == KW_LAST) begin
            next_state = CALC;
          end else begin
            next_state = KW_WAIT;
            next_idx   = bank_idx + 1'b1;
          end
        end
      end
      CALC: begin
        if (calc_done) next_state = DRAIN;
      end
      DRAIN: begin
        if (drain_last) next_state = READ;
      end
      READ: begin
        if (ofmd_rd_done) next_state = DONE;
      end
      DONE: begin
`ifdef CONV_FRAME_LOOP_EN
        next_state = IDLE;
        next_idx   = '0;
`else
        next_state = DONE;
`endif
      end
      default: begin
        next_state = IDLE;
        next_idx   = '0;
      end
    endcase
  end

  always_comb begin
    ifmd_ram_en = '0;
    ifmd_wr     = '0;
    kw_ram_en   = '0;
    kw_wr       = '0;
    for (int unsigned i = 0; i < IFMD_BANKS; i++) begin
      ifmd_wr[i]     = (state == IFMD_WR) && (bank_idx == BANK_IDX_W'(i));
      ifmd_ram_en[i] = ifmd_wr[i] || (state == CALC);
    end
    for (int unsigned i = 0; i < KW_BANKS; i++) begin
      kw_wr[i]     = (state == KW_WR) && (bank_idx == BANK_IDX_W'(i));
      kw_ram_en[i] = kw_wr[i] || (state == CALC);
    end
  end

  assign rd_enable     = (state == CALC);
  assign ofmd_ram_en   = (state == CALC) || (state == DRAIN) || (state == READ);
  assign ofmd_rd_en    = (state == READ);
  assign ifmd_wr_state = (state == IFMD_WAIT) || (state == IFMD_WR);
  assign kw_wr_state   = (state == KW_WAIT) || (state == KW_WR);
  assign done          = (state == DONE);

  conv_drain_pipe #(
    .POST_LAT (POST_LAT)
  ) u_drain_pipe (
    .clk             (clk),
    .rst             (rst),
    .calc_active     (state == CALC),
    .drain_active    (state == DRAIN),
    .ofmd_wr_addr_en (ofmd_wr_addr_en),
    .drain_last      (drain_last)
  );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench: DUT a = 2/4/3 banks/latency, DUT b = 3/1/1.
module tb_conv_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic       a_rst, a_st_ifmd, a_ifmd_done, a_st_kw, a_k5, a_kw_done, a_calc_done, a_rd_done;
  logic [1:0] a_ifmd_ram_en, a_ifmd_wr;
  logic [3:0] a_kw_ram_en, a_kw_wr;
  logic [2:0] a_bank_idx;
  logic       a_is_5x5, a_rd_enable, a_wa_en, a_ofmd_ram_en, a_ofmd_rd_en, a_out_st;
  logic       a_ifmd_st, a_kw_st, a_done;

  logic       b_rst, b_st_ifmd, b_ifmd_done, b_st_kw, b_k5, b_kw_done, b_calc_done, b_rd_done;
  logic [2:0] b_ifmd_ram_en, b_ifmd_wr;
  logic [0:0] b_kw_ram_en, b_kw_wr;
  logic [2:0] b_bank_idx;
  logic       b_is_5x5, b_rd_enable, b_wa_en, b_ofmd_ram_en, b_ofmd_rd_en, b_out_st;
  logic       b_ifmd_st, b_kw_st, b_done;

  conv_seq_ctrl #(.IFMD_BANKS(2), .KW_BANKS(4), .POST_LAT(3)) u_dut_a (
    .clk(clk), .rst(a_rst), .in_st_ifmd(a_st_ifmd), .ifmd_wr_done(a_ifmd_done),
    .in_st_kw(a_st_kw), .kw_is_5_5(a_k5), .kw_wr_done(a_kw_done), .calc_done(a_calc_done),
    .ofmd_rd_done(a_rd_done), .ifmd_ram_en(a_ifmd_ram_en), .ifmd_wr(a_ifmd_wr),
    .kw_ram_en(a_kw_ram_en), .kw_wr(a_kw_wr), .bank_idx(a_bank_idx), .is_5x5(a_is_5x5),
    .rd_enable(a_rd_enable), .ofmd_wr_addr_en(a_wa_en), .ofmd_ram_en(a_ofmd_ram_en),
    .ofmd_rd_en(a_ofmd_rd_en), .out_st(a_out_st), .ifmd_wr_state(a_ifmd_st),
    .kw_wr_state(a_kw_st), .done(a_done)
  );

  conv_seq_ctrl #(.IFMD_BANKS(3), .KW_BANKS(1), .POST_LAT(1)) u_dut_b (
    .clk(clk), .rst(b_rst), .in_st_ifmd(b_st_ifmd), .ifmd_wr_done(b_ifmd_done),
    .in_st_kw(b_st_kw), .kw_is_5_5(b_k5), .kw_wr_done(b_kw_done), .calc_done(b_calc_done),
    .ofmd_rd_done(b_rd_done), .ifmd_ram_en(b_ifmd_ram_en), .ifmd_wr(b_ifmd_wr),
    .kw_ram_en(b_kw_ram_en), .kw_wr(b_kw_wr), .bank_idx(b_bank_idx), .is_5x5(b_is_5x5),
    .rd_enable(b_rd_enable), .ofmd_wr_addr_en(b_wa_en), .ofmd_ram_en(b_ofmd_ram_en),
    .ofmd_rd_en(b_ofmd_rd_en), .out_st(b_out_st), .ifmd_wr_state(b_ifmd_st),
    .kw_wr_state(b_kw_st), .done(b_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete frame on DUT a; k5_first is the kernel mode offered with bank 0.
  task automatic run_frame_a(input logic k5_first);
    int lat, last_wa;
    a_st_ifmd = 1'b1; tick(); a_st_ifmd = 1'b0;
    check_val("a_ifmd_wr_b0", a_ifmd_wr, 32'h1);
    check_val("a_ifmd_en_b0", a_ifmd_ram_en, 32'h1);
    check_val("a_idx_b0", a_bank_idx, 32'h0);
    check_val("a_ifmd_state", a_ifmd_st, 32'h1);
    a_st_kw = 1'b1; tick(); a_st_kw = 1'b0;
    check_val("a_spur_kw_wr", a_ifmd_wr, 32'h1);
    check_val("a_spur_kw_kwwr", a_kw_wr, 32'h0);
    check_val("a_spur_kw_idx", a_bank_idx, 32'h0);
    a_st_ifmd = 1'b1; a_ifmd_done = 1'b1; tick(); a_st_ifmd = 1'b0; a_ifmd_done = 1'b0;
    check_val("a_done_wins_wr", a_ifmd_wr, 32'h0);
    check_val("a_done_wins_idx", a_bank_idx, 32'h1);
    tick();
    check_val("a_start_dropped", a_ifmd_wr, 32'h0);
    a_st_ifmd = 1'b1; tick(); a_st_ifmd = 1'b0;
    check_val("a_ifmd_wr_b1", a_ifmd_wr, 32'h2);
    check_val("a_ifmd_en_b1", a_ifmd_ram_en, 32'h2);
    a_ifmd_done = 1'b1; tick(); a_ifmd_done = 1'b0;
    check_val("a_kwwait_ifmd", a_ifmd_wr, 32'h0);
    check_val("a_kwwait_idx", a_bank_idx, 32'h0);
    check_val("a_kwwait_kwwr", a_kw_wr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      a_k5 = (k == 0) ? k5_first : ~k5_first;
      a_st_kw = 1'b1; tick(); a_st_kw = 1'b0;
      check_val("a_kw_wr", a_kw_wr, 32'(1 << k));
      check_val("a_kw_en", a_kw_ram_en, 32'(1 << k));
      check_val("a_kw_idx", a_bank_idx, 32'(k));
      check_val("a_is5x5_load", a_is_5x5, 32'(k5_first));
      if (k == 1) begin
        a_calc_done = 1'b1; tick(); a_calc_done = 1'b0;
        check_val("a_spur_calc_wr", a_kw_wr, 32'h2);
        check_val("a_spur_calc_idx", a_bank_idx, 32'h1);
      end
      a_kw_done = 1'b1; tick(); a_kw_done = 1'b0;
    end
    check_val("a_calc_rd", a_rd_enable, 32'h1);
    check_val("a_calc_ifmd_en", a_ifmd_ram_en, 32'h3);
    check_val("a_calc_kw_en", a_kw_ram_en, 32'hf);
    check_val("a_calc_ofmd_en", a_ofmd_ram_en, 32'h1);
    check_val("a_calc_wa0", a_wa_en, 32'h0);
    tick(); tick();
    check_val("a_calc_wa2", a_wa_en, 32'h1);
    a_calc_done = 1'b1;
    lat = 0; last_wa = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      a_calc_done = 1'b0;
      if (a_wa_en) last_wa = t;
      if (a_out_st) begin lat = t; break; end
    end
    check_val("a_out_st_lat", lat, 32'd4);
    check_val("a_last_wa", last_wa, 32'd2);
    check_val("a_read_rden", a_ofmd_rd_en, 32'h1);
    check_val("a_read_calc", a_rd_enable, 32'h0);
    tick();
    check_val("a_out_st_1cyc", a_out_st, 32'h0);
    check_val("a_read_hold", a_ofmd_rd_en, 32'h1);
    a_rd_done = 1'b1; tick(); a_rd_done = 1'b0;
    check_val("a_done", a_done, 32'h1);
    check_val("a_done_ofmd_en", a_ofmd_ram_en, 32'h0);
    check_val("a_done_is5x5", a_is_5x5, 32'(k5_first));
  endtask

  // Loads DUT b up to CALC with the given kernel mode.
  task automatic load_b(input logic k5);
    for (int i = 0; i < 3; i++) begin
      b_st_ifmd = 1'b1; tick(); b_st_ifmd = 1'b0;
      check_val("b_ifmd_wr", b_ifmd_wr, 32'(1 << i));
      b_ifmd_done = 1'b1; tick(); b_ifmd_done = 1'b0;
    end
    check_val("b_kwwait_ifmd", b_ifmd_wr, 32'h0);
    b_k5 = k5;
    b_st_kw = 1'b1; tick(); b_st_kw = 1'b0;
    check_val("b_kw_wr", b_kw_wr, 32'h1);
    check_val("b_is5x5", b_is_5x5, 32'(k5));
    b_kw_done = 1'b1; tick(); b_kw_done = 1'b0;
    check_val("b_calc_rd", b_rd_enable, 32'h1);
    check_val("b_calc_ifmd_en", b_ifmd_ram_en, 32'h7);
    check_val("b_calc_kw_en", b_kw_ram_en, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    {a_rst, a_st_ifmd, a_ifmd_done, a_st_kw, a_k5, a_kw_done, a_calc_done, a_rd_done} = '0;
    {b_rst, b_st_ifmd, b_ifmd_done, b_st_kw, b_k5, b_kw_done, b_calc_done, b_rd_done} = '0;
    tick(); tick();
    check_val("a_rst_ifmd_en", a_ifmd_ram_en, 32'h0);
    check_val("a_rst_kw_en", a_kw_ram_en, 32'h0);
    check_val("a_rst_idx", a_bank_idx, 32'h0);
    check_val("a_rst_ofmd", {a_rd_enable, a_wa_en, a_ofmd_ram_en, a_ofmd_rd_en}, 32'h0);
    check_val("a_rst_misc", {a_out_st, a_is_5x5, a_ifmd_st, a_kw_st, a_done}, 32'h0);
    a_rst = 1'b1;
    tick();
    run_frame_a(1'b1);
`ifdef CONV_FRAME_LOOP_EN
    tick();
    check_val("a_done_pulse1", a_done, 32'h0);
    run_frame_a(1'b0);
    tick();
    check_val("a_done_pulse2", a_done, 32'h0);
`else
    a_st_ifmd = 1'b1; tick(); a_st_ifmd = 1'b0;
    tick(); tick();
    check_val("a_done_hold", a_done, 32'h1);
    check_val("a_done_no_restart", a_ifmd_wr, 32'h0);
`endif

    b_rst = 1'b1;
    tick();
    load_b(1'b0);
    tick();
    check_val("b_calc_wa1", b_wa_en, 32'h1);
    b_calc_done = 1'b1;
    lat = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      b_calc_done = 1'b0;
      if (b_out_st) begin lat = t; break; end
    end
    check_val("b_out_st_lat", lat, 32'd2);
    b_rd_done = 1'b1; tick(); b_rd_done = 1'b0;
    check_val("b_done", b_done, 32'h1);

    b_rst = 1'b0; tick(); b_rst = 1'b1; tick();
    load_b(1'b1);
    tick();
    check_val("b_pre_rst_wa", b_wa_en, 32'h1);
    #3 b_rst = 1'b0;
    #1;
    check_val("b_arst_rd", b_rd_enable, 32'h0);
    check_val("b_arst_en", {b_ifmd_ram_en, b_kw_ram_en, b_ofmd_ram_en}, 32'h0);
    check_val("b_arst_wa", b_wa_en, 32'h0);
    check_val("b_arst_is5x5", b_is_5x5, 32'h0);
    #2 b_rst = 1'b1;
    tick();
    b_st_ifmd = 1'b1; tick(); b_st_ifmd = 1'b0;
    check_val("b_after_rst_wr", b_ifmd_wr, 32'h1);
    check_val("b_after_rst_idx", b_bank_idx, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
